cram_loader: RTL
================

# cram_loader

Bitstream loader for the fabric configuration chain. Accepts configuration words from a host over a valid/ready handshake, serializes them MSB-first onto the fabric's serial CRAM input while driving the shift enable, and counts exactly the chain length. It sits between the host interface and the fabric top level: its serial output feeds the fabric's config data input, and the fabric's config data output returns to it. An optional non-destructive readback pass rotates the chain once and checks its contents by CRC.

## Interface
Parameters:
- `WORD_WIDTH`, 8: host word width in bits.
- `CHAIN_LEN`, 1024: total CRAM bits in the fabric chain; must be ≥ 2.

Ports:
- `clk` input 1: single clock, shared with the fabric CRAM.
- `rst` input 1: asynchronous reset, active-high.
- `start` input 1: begin a load; honoured only in IDLE.
- `word_in` input WORD_WIDTH: host configuration word.
- `word_valid` input 1: `word_in` valid.
- `word_ready` output 1: loader accepts `word_in` this cycle.
- `config_en` output 1: fabric CRAM shift enable; one bit shifts per cycle while high.
- `config_data_out` output 1: serial bit to the fabric config data input.
- `config_data_in` input 1: serial bit from the fabric config data output (chain tail).
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when the operation completes.
- `error` output 1: readback CRC mismatch; sticky until the next accepted `start`.

## Operation
- States: IDLE, LOAD, VERIFY (only with the macro), DONE.
- IDLE: `start` is accepted when asserted. On acceptance, `bits_sent` clears, the holding register empties, `error` clears, and the state moves to LOAD. `start` is ignored in all other states.
- LOAD:
  - The holding register holds `bits_left` (0..WORD_WIDTH) unsent bits.
  - `word_ready` = LOAD && `bits_left` ≤ 1 && `bits_sent` + `bits_left` < CHAIN_LEN.
  - A handshake (`word_valid` && `word_ready`) loads `word_in` and sets `bits_left` to WORD_WIDTH.
  - A handshake while `bits_left` == 1 sends the last bit of the old word that same cycle. The new word's MSB follows on the next cycle, with no bubble.
  - While `bits_left` > 0, `config_en` = 1 and `config_data_out` = the current MSB. Each cycle the register shifts left, `bits_left` decrements and `bits_sent` increments.
  - If `bits_left` == 0 (host starved), `config_en` = 0 and the chain holds.
  - When `bits_sent` reaches CHAIN_LEN, any remaining low-order bits of the final word are discarded. The state moves to VERIFY (macro on) or DONE.
- VERIFY:
  - Runs for exactly CHAIN_LEN cycles with `config_en` = 1.
  - `config_data_out` = `config_data_in` (recirculation), so the chain returns to its loaded contents.
  - Returned bits appear in transmit order. They feed the readback CRC.
  - On the last cycle, `error` is set if the readback CRC ≠ the transmit CRC.
- DONE: `done` = 1 for one cycle, then IDLE.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, no reflection, no final XOR. The transmit CRC covers every bit sent with `config_en` = 1 in LOAD.

## Timing
- Reset values: `word_ready` 0, `config_en` 0, `config_data_out` 0, `busy` 0, `done` 0, `error` 0; state IDLE; counters and CRCs cleared.
- All outputs are registered.
- `start` sampled in cycle N gives `busy` = 1 and `word_ready` = 1 in N+1.
- The first bit is on `config_data_out` with `config_en` = 1 in the cycle after the first handshake.
- With a never-starved host, LOAD lasts exactly CHAIN_LEN enabled cycles.
- `done` pulses 1 cycle after the last LOAD bit (macro off), or 1 cycle after the last VERIFY cycle (macro on).
- `busy` falls in the cycle after `done`.
- Reset mid-operation: immediate return to IDLE with reset output values. Fabric contents are then undefined; the host must reload.
- `config_data_in` is sampled in VERIFY only; its value in other states has no effect.

## Configuration
- `CRAM_READBACK_EN` defined: the CRC logic and the VERIFY state are present, and `error` is functional.
- `CRAM_READBACK_EN` undefined: there is no CRC logic and no VERIFY state; LOAD goes straight to DONE, `error` is tied 0, and `config_data_in` is unused.

## Test plan
Bench fabric model: CHAIN_LEN-bit shift register, shifted on `config_en`.
- CHAIN_LEN = 20, WORD_WIDTH = 8; words 0xA5, 0x3C, 0xF0 with `word_valid` held high. Required response:
  - 20 consecutive `config_en` cycles.
  - Chain bit sequence A5·3C·F (the low 4 bits of 0xF0 are dropped).
  - Exactly 3 handshakes.
  - `done` one pulse.
- Same stimulus, but `word_valid` dropped for 5 cycles after the second word. Required response:
  - `config_en` = 0 for exactly those stall cycles.
  - Final chain contents identical to the first scenario.
- Macro on, clean chain model. Required response:
  - VERIFY lasts 20 cycles.
  - Chain contents are unchanged after VERIFY.
  - `error` = 0 and `done` pulses.
- Macro on, model flips one stored bit before VERIFY. Required response:
  - `error` = 1 after `done`.
  - `error` stays 1 until the next `start`, and clears when that `start` is accepted.
- `rst` asserted at `bits_sent` = 9. Required response:
  - All outputs 0 asynchronously.
  - A new `start` then loads all 20 bits correctly.
- `start` pulsed during LOAD: ignored; no counter disturbance, and only a single `done` is produced.

Source files
------------

// File: rtl/cram_loader.sv
// cram_loader: serial CRAM chain loader; define CRAM_READBACK_EN for the CRC readback (VERIFY) pass
module cram_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_en,
  output logic                  config_data_out,
  input  logic                  config_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CW = $clog2(CHAIN_LEN + WORD_WIDTH + 1);
  localparam int LW = $clog2(WORD_WIDTH + 1);
`ifdef CRAM_READBACK_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
  state_t state, state_n;
  logic [LW-1:0] bits_left, left_n;
  logic [CW-1:0] bits_sent, sent_n;
  logic [WORD_WIDTH-1:0] sr, sr_n;
  logic data_q, ready_n, en_n, data_n, busy_n, done_n, shifting_n, sending, hs;
  assign sending = state == LOAD && bits_left != '0;
  assign hs = word_valid && word_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      bits_left  <= '0;
      bits_sent  <= '0;
      sr         <= '0;
      word_ready <= 1'b0;
      config_en  <= 1'b0;
      data_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bits_left  <= left_n;
      bits_sent  <= sent_n;
      sr         <= sr_n;
      word_ready <= ready_n;
      config_en  <= en_n;
      data_q     <= data_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  always_comb begin
    state_n = state;
    left_n  = bits_left;
    sent_n  = bits_sent;
    sr_n    = sr;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        left_n  = '0;
        sent_n  = '0;
      end
      LOAD: begin
        sent_n = bits_sent + CW'(sending);
        left_n = hs ? LW'(WORD_WIDTH) : bits_left - LW'(sending);
        sr_n   = hs ? word_in : sr << 1;
        if (sent_n == CW'(CHAIN_LEN)) begin
`ifdef CRAM_READBACK_EN
          state_n = VERIFY;
`else
          state_n = DONE;
`endif
          left_n = '0;
          sent_n = '0;
        end
      end
`ifdef CRAM_READBACK_EN
      VERIFY: begin
        sent_n  = bits_sent + CW'(1);
        state_n = bits_sent == CW'(CHAIN_LEN - 1) ? DONE : VERIFY;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // outputs are computed from next-state values so every one leaves a flop
  always_comb begin
    shifting_n = state_n == LOAD && left_n != '0;
    ready_n    = state_n == LOAD && left_n <= LW'(1) && (sent_n + CW'(left_n)) < CW'(CHAIN_LEN);
    data_n     = shifting_n && sr_n[WORD_WIDTH-1];
    busy_n     = state_n != IDLE;
    done_n     = state_n == DONE;
`ifdef CRAM_READBACK_EN
    en_n = shifting_n || state_n == VERIFY;
`else
    en_n = shifting_n;
`endif
  end
`ifdef CRAM_READBACK_EN
  logic [15:0] crc_tx, crc_rx, rx_n;
  logic accept;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  assign accept = state == IDLE && start;
  assign rx_n = crc_step(crc_rx, config_data_in);
  // the chain tail loops straight back so CHAIN_LEN shifts restore the contents
  assign config_data_out = state == VERIFY ? config_data_in : data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      crc_tx <= '0;
      crc_rx <= '0;
      error  <= 1'b0;
    end else if (accept) begin
      crc_tx <= 16'hFFFF;
      crc_rx <= 16'hFFFF;
      error  <= 1'b0;
    end else begin
      if (sending) crc_tx <= crc_step(crc_tx, sr[WORD_WIDTH-1]);
      if (state == VERIFY) crc_rx <= rx_n;
      if (state == VERIFY && bits_sent == CW'(CHAIN_LEN - 1) && rx_n != crc_tx) error <= 1'b1;
    end
`else
  logic unused_data_in;
  assign unused_data_in = config_data_in;
  assign config_data_out = data_q;
  assign error = 1'b0;
`endif
endmodule
